reg_scoreboard: RTL and testbench
=================================

Name: reg_scoreboard

Overview:
- Tracks outstanding register writes between decode/issue and writeback. It consumes the same scalar/vector write-enable pair (regWrite/regWriteV) that the decode stage produces.
- Issue marks a destination pending; writeback clears it. Source operands of the instruction being issued are checked against pending writes, and a stall is raised on RAW hazards or counter overflow.
- Sits beside the decode/issue stage and takes the writeback-stage enables as its clear port.

Parameters:
- NREG, 16, registers per file (scalar and vector); index width is 4 bits.
- CNTW, 2, width of the per-register outstanding-write counter; maximum 2^CNTW-1.
- WB_BYPASS, 1, when 1 a same-cycle writeback that retires the last pending write to a source suppresses the hazard.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- iss_valid  in  1  instruction presented for issue
- iss_rd  in  4  destination register
- iss_regWrite  in  1  destination is scalar file
- iss_regWriteV  in  1  destination is vector file
- iss_rs1  in  4  source 1 index
- iss_rs2  in  4  source 2 index
- iss_rs1_v  in  1  source 1 read from vector file
- iss_rs2_v  in  1  source 2 read from vector file
- iss_rs1_en  in  1  source 1 used
- iss_rs2_en  in  1  source 2 used
- wb_rd  in  4  writeback destination
- wb_regWrite  in  1  scalar writeback this cycle
- wb_regWriteV  in  1  vector writeback this cycle
- stall  out  1  issue blocked this cycle (combinational)
- iss_accept  out  1  iss_valid && !stall
- pend_s  out  16  scalar pending bitmap (registered; count != 0)
- pend_v  out  16  vector pending bitmap (registered)
- wb_err  out  1  sticky: writeback to a register with count 0
- stall_cnt  out  16  saturating count of stalled cycles

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All counters cleared to 0.
  - pend_s=pend_v=0, wb_err=0, stall_cnt=0.
  - Reset mid-operation discards all outstanding state; in-flight writebacks after reset are treated as spurious and set wb_err.
- Register 0 in either file is never pending:
  - Issue or writeback with rd=0 is ignored.
  - Sources with index 0 never cause a hazard.
- Hazard, per enabled source rsN:
  - hazN = count[file(rsN_v)][rsN] != 0 && rsN != 0.
  - With WB_BYPASS=1, hazN is cleared when wb targets the same file and index this cycle and count==1.
- Dest-full: the destination counter in the selected file equals the maximum and no same-cycle writeback targets it.
- stall = iss_valid && (haz1 || haz2 || dest_full).
  - No WAW stall: multiple outstanding writes to one register are legal up to the counter maximum.
- iss_regWrite and iss_regWriteV both 1 is illegal:
  - Treated as scalar only.
  - wb_regWrite and wb_regWriteV both 1 is treated the same way.
- Counter update per register per edge: next = count + inc − dec.
  - inc = iss_accept targeting it.
  - dec = writeback targeting it with count>0.
  - Simultaneous issue and writeback to the same register leaves the count unchanged.
  - Writeback with count==0 and no same-cycle inc: count stays 0, wb_err set.
- Latency: iss_accept at edge N makes pend bit 1 after edge N; a source check in cycle N+1 stalls. Writeback at edge M clears the pend bit after M (or the same cycle via bypass).
- stall_cnt increments each cycle stall=1 and saturates at 0xFFFF.

Test Plan:
- Reset, then issue rd=5 scalar with no sources -> iss_accept=1; next cycle pend_s=0x0020, stall=0.
- Issue rd=5 scalar, next cycle issue with rs1=5 scalar -> stall=1 until wb_rd=5 wb_regWrite=1. With WB_BYPASS=1, stall=0 in the writeback cycle; stall_cnt counts the stalled cycles.
- Issue rd=3 vector, then read rs1=3 scalar -> no stall (different files); pend_v=0x0008, pend_s=0.
- Issue rd=7 scalar three times with no writeback -> 4th issue stalls (dest_full). A writeback to 7 in the same cycle as the 4th issue lets it accept; count stays 3.
- Issue rd=0, then read rs1=0 -> never pending, never stalls; writeback to 0 leaves wb_err=0.
- Writeback rd=9 scalar with nothing pending -> wb_err=1 and stays 1. Assert rst_n=0 for one edge -> wb_err=0, all bitmaps 0, stall_cnt=0.

Source files
------------

// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register outstanding-write counters for the scalar and vector files.
// Issue increments a counter, writeback decrements it, and RAW hazards or a full counter stall issue.
module reg_scoreboard #(
    parameter int NREG      = 16,
    parameter int CNTW      = 2,
    parameter int WB_BYPASS = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     iss_valid,
    input  logic [$clog2(NREG)-1:0]  iss_rd,
    input  logic                     iss_regWrite,
    input  logic                     iss_regWriteV,
    input  logic [$clog2(NREG)-1:0]  iss_rs1,
    input  logic [$clog2(NREG)-1:0]  iss_rs2,
    input  logic                     iss_rs1_v,
    input  logic                     iss_rs2_v,
    input  logic                     iss_rs1_en,
    input  logic                     iss_rs2_en,
    input  logic [$clog2(NREG)-1:0]  wb_rd,
    input  logic                     wb_regWrite,
    input  logic                     wb_regWriteV,
    output logic                     stall,
    output logic                     iss_accept,
    output logic [NREG-1:0]          pend_s,
    output logic [NREG-1:0]          pend_v,
    output logic                     wb_err,
    output logic [15:0]              stall_cnt
);

    localparam int IW = $clog2(NREG);
    localparam logic [CNTW-1:0] CNT_MAX  = {CNTW{1'b1}};
    localparam logic [CNTW-1:0] CNT_ZERO = {CNTW{1'b0}};
    localparam logic [CNTW-1:0] CNT_ONE  = {{(CNTW-1){1'b0}}, 1'b1};
    localparam logic [IW-1:0]   IDX_ZERO = {IW{1'b0}};
    localparam logic            BYPASS   = (WB_BYPASS != 0);

    logic [CNTW-1:0] r_cnt_s [NREG];
    logic [CNTW-1:0] r_cnt_v [NREG];
    logic [NREG-1:0] r_pend_s;
    logic [NREG-1:0] r_pend_v;
    logic            r_wb_err;
    logic [15:0]     r_stall_cnt;

    logic [CNTW-1:0] w_cnt_s_nxt [NREG];
    logic [CNTW-1:0] w_cnt_v_nxt [NREG];
    logic [NREG-1:0] w_pend_s_nxt;
    logic [NREG-1:0] w_pend_v_nxt;
    logic            w_iss_s;
    logic            w_iss_v;
    logic            w_wb_s;
    logic            w_wb_v;
    logic [CNTW-1:0] w_rs1_cnt;
    logic [CNTW-1:0] w_rs2_cnt;
    logic [CNTW-1:0] w_rd_cnt;
    logic            w_rs1_wb;
    logic            w_rs2_wb;
    logic            w_rd_wb;
    logic            w_haz1;
    logic            w_haz2;
    logic            w_dest_full;
    logic            w_stall;
    logic            w_accept;
    logic            w_err;

    // Decode file selects (both-set means scalar), hazards, dest-full and issue handshake.
    always_comb begin
        w_iss_s   = iss_regWrite && (iss_rd != IDX_ZERO);
        w_iss_v   = iss_regWriteV && !iss_regWrite && (iss_rd != IDX_ZERO);
        w_wb_s    = wb_regWrite && (wb_rd != IDX_ZERO);
        w_wb_v    = wb_regWriteV && !wb_regWrite && (wb_rd != IDX_ZERO);

        w_rs1_cnt = iss_rs1_v ? r_cnt_v[iss_rs1] : r_cnt_s[iss_rs1];
        w_rs2_cnt = iss_rs2_v ? r_cnt_v[iss_rs2] : r_cnt_s[iss_rs2];
        w_rd_cnt  = iss_regWrite ? r_cnt_s[iss_rd] : r_cnt_v[iss_rd];

        w_rs1_wb  = (iss_rs1_v ? w_wb_v : w_wb_s) && (wb_rd == iss_rs1);
        w_rs2_wb  = (iss_rs2_v ? w_wb_v : w_wb_s) && (wb_rd == iss_rs2);
        w_rd_wb   = (iss_regWrite ? w_wb_s : w_wb_v) && (wb_rd == iss_rd);

        // A writeback retiring the only pending write forwards its data this cycle.
        w_haz1 = iss_rs1_en && (iss_rs1 != IDX_ZERO) && (w_rs1_cnt != CNT_ZERO)
                 && !(BYPASS && w_rs1_wb && (w_rs1_cnt == CNT_ONE));
        w_haz2 = iss_rs2_en && (iss_rs2 != IDX_ZERO) && (w_rs2_cnt != CNT_ZERO)
                 && !(BYPASS && w_rs2_wb && (w_rs2_cnt == CNT_ONE));
        w_dest_full = (w_iss_s || w_iss_v) && (w_rd_cnt == CNT_MAX) && !w_rd_wb;

        w_stall  = iss_valid && (w_haz1 || w_haz2 || w_dest_full);
        w_accept = iss_valid && !w_stall;
    end

    // Next counter values: +1 on accepted issue, -1 on writeback, spurious writeback flags an error.
    always_comb begin
        w_err        = 1'b0;
        w_pend_s_nxt = {NREG{1'b0}};
        w_pend_v_nxt = {NREG{1'b0}};
        for (int i = 0; i < NREG; i++) begin
            logic inc_s;
            logic inc_v;
            logic dec_s;
            logic dec_v;
            inc_s = w_accept && w_iss_s && (iss_rd == IW'(i));
            inc_v = w_accept && w_iss_v && (iss_rd == IW'(i));
            dec_s = w_wb_s && (wb_rd == IW'(i));
            dec_v = w_wb_v && (wb_rd == IW'(i));

            if (inc_s && !dec_s) begin
                w_cnt_s_nxt[i] = r_cnt_s[i] + CNT_ONE;
            end else if (!inc_s && dec_s && (r_cnt_s[i] != CNT_ZERO)) begin
                w_cnt_s_nxt[i] = r_cnt_s[i] - CNT_ONE;
            end else begin
                w_cnt_s_nxt[i] = r_cnt_s[i];
            end

            if (inc_v && !dec_v) begin
                w_cnt_v_nxt[i] = r_cnt_v[i] + CNT_ONE;
            end else if (!inc_v && dec_v && (r_cnt_v[i] != CNT_ZERO)) begin
                w_cnt_v_nxt[i] = r_cnt_v[i] - CNT_ONE;
            end else begin
                w_cnt_v_nxt[i] = r_cnt_v[i];
            end

            if ((dec_s && !inc_s && (r_cnt_s[i] == CNT_ZERO)) ||
                (dec_v && !inc_v && (r_cnt_v[i] == CNT_ZERO))) begin
                w_err = 1'b1;
            end else begin
                w_err = w_err;
            end

            w_pend_s_nxt[i] = (w_cnt_s_nxt[i] != CNT_ZERO);
            w_pend_v_nxt[i] = (w_cnt_v_nxt[i] != CNT_ZERO);
        end
    end

    // Counter, bitmap, sticky error and stall-counter state with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_cnt_s[i] <= CNT_ZERO;
                r_cnt_v[i] <= CNT_ZERO;
            end
            r_pend_s    <= {NREG{1'b0}};
            r_pend_v    <= {NREG{1'b0}};
            r_wb_err    <= 1'b0;
            r_stall_cnt <= 16'h0000;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                r_cnt_s[i] <= w_cnt_s_nxt[i];
                r_cnt_v[i] <= w_cnt_v_nxt[i];
            end
            r_pend_s <= w_pend_s_nxt;
            r_pend_v <= w_pend_v_nxt;
            r_wb_err <= r_wb_err || w_err;
            if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'h0001;
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
        end
    end

    assign stall      = w_stall;
    assign iss_accept = w_accept;
    assign pend_s     = r_pend_s;
    assign pend_v     = r_pend_v;
    assign wb_err     = r_wb_err;
    assign stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Table-driven bench for reg_scoreboard: combinational stall/accept checked before each edge,
// registered outputs checked after it from a queue of expected values.
module tb_reg_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        iss_valid;
    logic [3:0]  iss_rd;
    logic        iss_regWrite;
    logic        iss_regWriteV;
    logic [3:0]  iss_rs1;
    logic [3:0]  iss_rs2;
    logic        iss_rs1_v;
    logic        iss_rs2_v;
    logic        iss_rs1_en;
    logic        iss_rs2_en;
    logic [3:0]  wb_rd;
    logic        wb_regWrite;
    logic        wb_regWriteV;
    logic        stall;
    logic        iss_accept;
    logic [15:0] pend_s;
    logic [15:0] pend_v;
    logic        wb_err;
    logic [15:0] stall_cnt;

    int checks;
    int failures;

    reg_scoreboard #(.NREG(16), .CNTW(2), .WB_BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .iss_valid(iss_valid), .iss_rd(iss_rd),
        .iss_regWrite(iss_regWrite), .iss_regWriteV(iss_regWriteV),
        .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rs1_v(iss_rs1_v), .iss_rs2_v(iss_rs2_v),
        .iss_rs1_en(iss_rs1_en), .iss_rs2_en(iss_rs2_en), .wb_rd(wb_rd),
        .wb_regWrite(wb_regWrite), .wb_regWriteV(wb_regWriteV), .stall(stall),
        .iss_accept(iss_accept), .pend_s(pend_s), .pend_v(pend_v), .wb_err(wb_err),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // File codes: 0 none, 1 scalar, 2 vector, 3 both (dest/writeback only).
    typedef struct {
        logic        rst_n;
        logic        v;
        logic [3:0]  rd;
        logic [1:0]  df;
        logic [3:0]  rs1;
        logic [1:0]  f1;
        logic [3:0]  rs2;
        logic [1:0]  f2;
        logic [3:0]  wbrd;
        logic [1:0]  wbf;
        logic        es;
        logic        ea;
        logic [15:0] eps;
        logic [15:0] epv;
        logic        eerr;
        logic [15:0] ecnt;
    } vec_t;

    typedef struct {
        logic [15:0] ps;
        logic [15:0] pv;
        logic        err;
        logic [15:0] cnt;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    function automatic vec_t mk(input logic r, input logic v, input logic [3:0] rd, input logic [1:0] df,
                                input logic [3:0] rs1, input logic [1:0] f1, input logic [3:0] rs2,
                                input logic [1:0] f2, input logic [3:0] wbrd, input logic [1:0] wbf,
                                input logic es, input logic ea, input logic [15:0] eps,
                                input logic [15:0] epv, input logic eerr, input logic [15:0] ecnt);
        vec_t t;
        t.rst_n = r;  t.v = v;     t.rd = rd;     t.df = df;
        t.rs1 = rs1;  t.f1 = f1;   t.rs2 = rs2;   t.f2 = f2;
        t.wbrd = wbrd; t.wbf = wbf; t.es = es;    t.ea = ea;
        t.eps = eps;  t.epv = epv; t.eerr = eerr; t.ecnt = ecnt;
        return t;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=0x%0h expected=0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t t, input int idx);
        exp_t e;
        exp_t got;
        @(negedge clk);
        rst_n         = t.rst_n;
        iss_valid     = t.v;
        iss_rd        = t.rd;
        iss_regWrite  = t.df[0];
        iss_regWriteV = t.df[1];
        iss_rs1       = t.rs1;
        iss_rs1_en    = |t.f1;
        iss_rs1_v     = t.f1[1];
        iss_rs2       = t.rs2;
        iss_rs2_en    = |t.f2;
        iss_rs2_v     = t.f2[1];
        wb_rd         = t.wbrd;
        wb_regWrite   = t.wbf[0];
        wb_regWriteV  = t.wbf[1];
        e.ps = t.eps; e.pv = t.epv; e.err = t.eerr; e.cnt = t.ecnt;
        sb.push_back(e);
        #2;
        chk("stall", idx, {31'd0, stall}, {31'd0, t.es});
        chk("iss_accept", idx, {31'd0, iss_accept}, {31'd0, t.ea});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty step=%0d actual=0 expected=1", idx);
        end else begin
            got = sb.pop_front();
            chk("pend_s", idx, {16'd0, pend_s}, {16'd0, got.ps});
            chk("pend_v", idx, {16'd0, pend_v}, {16'd0, got.pv});
            chk("wb_err", idx, {31'd0, wb_err}, {31'd0, got.err});
            chk("stall_cnt", idx, {16'd0, stall_cnt}, {16'd0, got.cnt});
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0; iss_valid = 1'b0; iss_rd = 4'd0; iss_regWrite = 1'b0; iss_regWriteV = 1'b0;
        iss_rs1 = 4'd0; iss_rs2 = 4'd0; iss_rs1_v = 1'b0; iss_rs2_v = 1'b0;
        iss_rs1_en = 1'b0; iss_rs2_en = 1'b0; wb_rd = 4'd0; wb_regWrite = 1'b0; wb_regWriteV = 1'b0;

        //                r  v  rd   df  rs1 f1 rs2 f2 wbrd wbf es ea  pend_s    pend_v    err cnt
        tbl.push_back(mk(0, 0, 4'd0, 0, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'd0));  // 0 reset
        tbl.push_back(mk(1, 1, 4'd5, 1, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 1, 16'h0020, 16'h0000, 0, 16'd0));  // 1 issue r5
        tbl.push_back(mk(1, 1, 4'd1, 1, 4'd5, 1, 4'd0, 0, 4'd0, 0, 1, 0, 16'h0020, 16'h0000, 0, 16'd1));  // 2 RAW
        tbl.push_back(mk(1, 1, 4'd1, 1, 4'd5, 1, 4'd0, 0, 4'd0, 0, 1, 0, 16'h0020, 16'h0000, 0, 16'd2));  // 3 RAW
        tbl.push_back(mk(1, 1, 4'd1, 1, 4'd5, 1, 4'd0, 0, 4'd5, 1, 0, 1, 16'h0002, 16'h0000, 0, 16'd2));  // 4 bypass
        tbl.push_back(mk(1, 0, 4'd0, 0, 4'd0, 0, 4'd0, 0, 4'd1, 1, 0, 0, 16'h0000, 16'h0000, 0, 16'd2));  // 5 wb r1
        tbl.push_back(mk(1, 1, 4'd3, 2, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 1, 16'h0000, 16'h0008, 0, 16'd2));  // 6 issue v3
        tbl.push_back(mk(1, 1, 4'd0, 0, 4'd3, 1, 4'd0, 0, 4'd0, 0, 0, 1, 16'h0000, 16'h0008, 0, 16'd2));  // 7 read s3
        tbl.push_back(mk(1, 1, 4'd0, 0, 4'd3, 2, 4'd0, 0, 4'd0, 0, 1, 0, 16'h0000, 16'h0008, 0, 16'd3));  // 8 read v3
        tbl.push_back(mk(1, 0, 4'd0, 0, 4'd0, 0, 4'd0, 0, 4'd3, 2, 0, 0, 16'h0000, 16'h0000, 0, 16'd3));  // 9 wb v3
        tbl.push_back(mk(1, 1, 4'd7, 1, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 1, 16'h0080, 16'h0000, 0, 16'd3));  // 10 r7 #1
        tbl.push_back(mk(1, 1, 4'd7, 1, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 1, 16'h0080, 16'h0000, 0, 16'd3));  // 11 r7 #2
        tbl.push_back(mk(1, 1, 4'd7, 1, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 1, 16'h0080, 16'h0000, 0, 16'd3));  // 12 r7 #3
        tbl.push_back(mk(1, 1, 4'd7, 1, 4'd0, 0, 4'd0, 0, 4'd0, 0, 1, 0, 16'h0080, 16'h0000, 0, 16'd4));  // 13 full
        tbl.push_back(mk(1, 1, 4'd7, 1, 4'd0, 0, 4'd0, 0, 4'd7, 1, 0, 1, 16'h0080, 16'h0000, 0, 16'd4));  // 14 full+wb
        tbl.push_back(mk(1, 0, 4'd0, 0, 4'd0, 0, 4'd0, 0, 4'd7, 1, 0, 0, 16'h0080, 16'h0000, 0, 16'd4));  // 15 cnt 2
        tbl.push_back(mk(1, 0, 4'd0, 0, 4'd0, 0, 4'd0, 0, 4'd7, 1, 0, 0, 16'h0080, 16'h0000, 0, 16'd4));  // 16 cnt 1
        tbl.push_back(mk(1, 0, 4'd0, 0, 4'd0, 0, 4'd0, 0, 4'd7, 1, 0, 0, 16'h0000, 16'h0000, 0, 16'd4));  // 17 cnt 0
        tbl.push_back(mk(1, 1, 4'd0, 1, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 1, 16'h0000, 16'h0000, 0, 16'd4));  // 18 issue r0
        tbl.push_back(mk(1, 1, 4'd0, 0, 4'd0, 1, 4'd0, 2, 4'd0, 0, 0, 1, 16'h0000, 16'h0000, 0, 16'd4));  // 19 read r0
        tbl.push_back(mk(1, 0, 4'd0, 0, 4'd0, 0, 4'd0, 0, 4'd0, 1, 0, 0, 16'h0000, 16'h0000, 0, 16'd4));  // 20 wb r0
        tbl.push_back(mk(1, 1, 4'd4, 3, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 1, 16'h0010, 16'h0000, 0, 16'd4));  // 21 both dest
        tbl.push_back(mk(1, 0, 4'd0, 0, 4'd0, 0, 4'd0, 0, 4'd4, 3, 0, 0, 16'h0000, 16'h0000, 0, 16'd4));  // 22 both wb
        tbl.push_back(mk(1, 0, 4'd0, 0, 4'd0, 0, 4'd0, 0, 4'd9, 1, 0, 0, 16'h0000, 16'h0000, 1, 16'd4));  // 23 spurious
        tbl.push_back(mk(1, 1, 4'd6, 1, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 1, 16'h0040, 16'h0000, 1, 16'd4));  // 24 sticky
        tbl.push_back(mk(0, 0, 4'd0, 0, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'd0));  // 25 reset
        tbl.push_back(mk(1, 0, 4'd0, 0, 4'd0, 0, 4'd0, 0, 4'd6, 1, 0, 0, 16'h0000, 16'h0000, 1, 16'd0));  // 26 stale wb
        tbl.push_back(mk(0, 0, 4'd0, 0, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'd0));  // 27 reset
        tbl.push_back(mk(1, 1, 4'd8, 1, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 1, 16'h0100, 16'h0000, 0, 16'd0));  // 28 issue r8
        tbl.push_back(mk(1, 1, 4'd0, 0, 4'd2, 1, 4'd8, 1, 4'd0, 0, 1, 0, 16'h0100, 16'h0000, 0, 16'd1));  // 29 rs2 RAW
        tbl.push_back(mk(1, 1, 4'd0, 0, 4'd2, 1, 4'd8, 1, 4'd8, 1, 0, 1, 16'h0000, 16'h0000, 0, 16'd1));  // 30 bypass
        tbl.push_back(mk(1, 1, 4'd8, 1, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 1, 16'h0100, 16'h0000, 0, 16'd1));  // 31 issue r8
        tbl.push_back(mk(1, 1, 4'd0, 0, 4'd0, 0, 4'd8, 0, 4'd0, 0, 0, 1, 16'h0100, 16'h0000, 0, 16'd1));  // 32 rs2 off
        tbl.push_back(mk(1, 1, 4'd8, 1, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 1, 16'h0100, 16'h0000, 0, 16'd1));  // 33 cnt 2
        tbl.push_back(mk(1, 1, 4'd0, 0, 4'd8, 1, 4'd0, 0, 4'd8, 1, 1, 0, 16'h0100, 16'h0000, 0, 16'd2));  // 34 no byp
        tbl.push_back(mk(1, 1, 4'd0, 0, 4'd8, 1, 4'd0, 0, 4'd8, 1, 0, 1, 16'h0000, 16'h0000, 0, 16'd2));  // 35 bypass

        foreach (tbl[i]) apply(tbl[i], i);

        // Multi-cycle stall on r10 held for five cycles, then released by its writeback.
        apply(mk(1, 1, 4'd10, 1, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 1, 16'h0400, 16'h0000, 0, 16'd2), 100);
        for (int k = 1; k <= 5; k++) begin
            apply(mk(1, 1, 4'd0, 0, 4'd10, 1, 4'd0, 0, 4'd0, 0, 1, 0, 16'h0400, 16'h0000, 0,
                     16'(2 + k)), 100 + k);
        end
        apply(mk(1, 1, 4'd0, 0, 4'd10, 1, 4'd0, 0, 4'd10, 1, 0, 1, 16'h0000, 16'h0000, 0, 16'd7), 106);

        // Vector RAW on v11 via rs2 with the writeback arriving in the scalar file (no bypass).
        apply(mk(1, 1, 4'd11, 2, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 1, 16'h0000, 16'h0800, 0, 16'd7), 107);
        apply(mk(1, 1, 4'd0, 0, 4'd0, 0, 4'd11, 2, 4'd11, 1, 1, 0, 16'h0000, 16'h0800, 1, 16'd8), 108);
        apply(mk(1, 1, 4'd0, 0, 4'd0, 0, 4'd11, 2, 4'd11, 2, 0, 1, 16'h0000, 16'h0000, 1, 16'd8), 109);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
